// File: rtl/ex_stage_if.sv
// Bus between the decode stage (master) and the execute stage (slave).
interface ex_stage_if;
    logic        InValid;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [31:0] Ed32;
    logic [31:0] NPC;
    logic        Busy;
    logic        OutValid;
    logic [31:0] Result;
    logic [31:0] StoreData;
    logic        BrTaken;
    logic [31:0] BrTarget;

    modport master (
        output InValid, Ins, Rdata1, Rdata2, Ed32, NPC,
        input  Busy, OutValid, Result, StoreData, BrTaken, BrTarget
    );

    modport slave (
        input  InValid, Ins, Rdata1, Rdata2, Ed32, NPC,
        output Busy, OutValid, Result, StoreData, BrTaken, BrTarget
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU/branch/address path, HI/LO registers and an
// iterative multiply/divide unit that stalls upstream through Busy.
module ex_stage #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter logic [31:0] HILO_INIT      = 32'h0
) (
    input logic       CLK,
    input logic       RST,
    ex_stage_if.slave bus
);
    localparam int unsigned N = 32 / BITS_PER_CYCLE;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR    = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO  = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB   = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR   = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t      r_state, w_state_next;
    logic        w_busy, w_accept;
    logic [5:0]  w_op, w_func;
    logic [4:0]  w_shamt;
    logic [31:0] w_imm_sext, w_imm_zext, w_br_target, w_result;
    logic        w_br_taken, w_is_md, w_mthi, w_mtlo;

    logic        r_out_valid, r_br_taken;
    logic [31:0] r_result, r_store_data, r_br_target, r_hi, r_lo;

    // Mult/div working state: {r_md_hi, r_md_lo} is the product / {remainder, quotient}.
    logic [31:0] r_md_hi, r_md_lo, r_md_b, r_md_a;
    logic        r_md_div, r_neg_q, r_neg_r, r_div0;
    logic [5:0]  r_cnt;
    logic [31:0] w_step_hi, w_step_lo, w_a_mag, w_b_mag;
    logic        w_a_neg, w_b_neg;
    logic [32:0] w_sum;
    logic [33:0] w_tmp, w_diff;
    logic [63:0] w_prod;
    logic [31:0] w_fin_hi, w_fin_lo;
    logic        w_unused;

    assign w_op        = bus.Ins[31:26];
    assign w_func      = bus.Ins[5:0];
    assign w_shamt     = bus.Ins[10:6];
    assign w_imm_sext  = {{16{bus.Ed32[15]}}, bus.Ed32[15:0]};
    assign w_imm_zext  = {16'h0, bus.Ed32[15:0]};
    assign w_br_target = bus.NPC + {{14{bus.Ins[15]}}, bus.Ins[15:0], 2'b00};
    assign w_accept    = bus.InValid && !w_busy;
    assign w_unused    = ^{bus.Ins[25:16], w_diff[32], w_tmp[33:32]};

    // Single-cycle decode and ALU.
    always_comb begin
        w_result   = '0;
        w_br_taken = 1'b0;
        w_is_md    = 1'b0;
        w_mthi     = 1'b0;
        w_mtlo     = 1'b0;
        case (w_op)
            OP_SPECIAL: begin
                case (w_func)
                    F_SLL:   w_result = bus.Rdata2 << w_shamt;
                    F_SRL:   w_result = bus.Rdata2 >> w_shamt;
                    F_SRA:   w_result = 32'($signed(bus.Rdata2) >>> w_shamt);
                    F_SLLV:  w_result = bus.Rdata2 << bus.Rdata1[4:0];
                    F_SRLV:  w_result = bus.Rdata2 >> bus.Rdata1[4:0];
                    F_SRAV:  w_result = 32'($signed(bus.Rdata2) >>> bus.Rdata1[4:0]);
                    F_JR, F_JALR: w_result = bus.NPC + 32'd4;
                    F_MFHI:  w_result = r_hi;
                    F_MFLO:  w_result = r_lo;
                    F_MTHI:  w_mthi = 1'b1;
                    F_MTLO:  w_mtlo = 1'b1;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: w_is_md = 1'b1;
                    F_ADD, F_ADDU: w_result = bus.Rdata1 + bus.Rdata2;
                    F_SUB, F_SUBU: w_result = bus.Rdata1 - bus.Rdata2;
                    F_AND:   w_result = bus.Rdata1 & bus.Rdata2;
                    F_OR:    w_result = bus.Rdata1 | bus.Rdata2;
                    F_XOR:   w_result = bus.Rdata1 ^ bus.Rdata2;
                    F_NOR:   w_result = ~(bus.Rdata1 | bus.Rdata2);
                    F_SLT:   w_result = {31'h0, $signed(bus.Rdata1) < $signed(bus.Rdata2)};
                    F_SLTU:  w_result = {31'h0, bus.Rdata1 < bus.Rdata2};
                    default: ;
                endcase
            end
            OP_JAL:            w_result = bus.NPC + 32'd4;
            OP_BEQ:            w_br_taken = (bus.Rdata1 == bus.Rdata2);
            OP_BNE:            w_br_taken = (bus.Rdata1 != bus.Rdata2);
            OP_ADDI, OP_ADDIU: w_result = bus.Rdata1 + bus.Ed32;
            OP_SLTI:           w_result = {31'h0, $signed(bus.Rdata1) < $signed(bus.Ed32)};
            OP_ANDI:           w_result = bus.Rdata1 & w_imm_zext;
            OP_ORI:            w_result = bus.Rdata1 | w_imm_zext;
            OP_XORI:           w_result = bus.Rdata1 ^ w_imm_zext;
            OP_LUI:            w_result = {bus.Ins[15:0], 16'h0};
            OP_LW, OP_SW:      w_result = bus.Rdata1 + w_imm_sext;
            default: ;
        endcase
    end

    // Registered result, flags and store data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_br_taken   <= 1'b0;
            r_br_target  <= '0;
        end else if (w_accept) begin
            r_out_valid  <= !w_is_md;
            r_result     <= w_result;
            r_store_data <= bus.Rdata2;
            r_br_taken   <= w_br_taken;
            r_br_target  <= w_br_target;
        end else begin
            r_out_valid  <= 1'b0;
        end
    end

    // Mult/div FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    // Mult/div FSM next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept && w_is_md) w_state_next = StRun;
            StRun:   if (r_cnt == 6'd0) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Mult/div FSM outputs.
    always_comb begin
        w_busy = (r_state != StIdle);
    end

    // Operand magnitudes; MULTU/DIVU (func[0]=1) treat operands as unsigned.
    assign w_a_neg = !w_func[0] && bus.Rdata1[31];
    assign w_b_neg = !w_func[0] && bus.Rdata2[31];
    assign w_a_mag = w_a_neg ? -bus.Rdata1 : bus.Rdata1;
    assign w_b_mag = w_b_neg ? -bus.Rdata2 : bus.Rdata2;

    // BITS_PER_CYCLE iterations of shift-add multiply or restoring divide.
    always_comb begin
        w_step_hi = r_md_hi;
        w_step_lo = r_md_lo;
        w_sum     = '0;
        w_tmp     = '0;
        w_diff    = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (r_md_div) begin
                w_tmp     = {1'b0, w_step_hi, w_step_lo[31]};
                w_diff    = w_tmp - {2'b00, r_md_b};
                w_step_lo = {w_step_lo[30:0], !w_diff[33]};
                w_step_hi = w_diff[33] ? w_tmp[31:0] : w_diff[31:0];
            end else begin
                w_sum     = {1'b0, w_step_hi} + (w_step_lo[0] ? {1'b0, r_md_b} : 33'd0);
                w_step_lo = {w_sum[0], w_step_lo[31:1]};
                w_step_hi = w_sum[32:1];
            end
        end
    end

    // Sign fix-up of the finished magnitudes.
    always_comb begin
        w_prod = r_neg_q ? -{r_md_hi, r_md_lo} : {r_md_hi, r_md_lo};
        if (!r_md_div) begin
            w_fin_hi = w_prod[63:32];
            w_fin_lo = w_prod[31:0];
        end else if (r_div0) begin
            w_fin_hi = r_md_a;
            w_fin_lo = 32'hFFFF_FFFF;
        end else begin
            w_fin_hi = r_neg_r ? -r_md_hi : r_md_hi;
            w_fin_lo = r_neg_q ? -r_md_lo : r_md_lo;
        end
    end

    // Mult/div operand latch and iteration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_md_hi  <= '0;
            r_md_lo  <= '0;
            r_md_b   <= '0;
            r_md_a   <= '0;
            r_md_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_md) begin
            r_md_hi  <= '0;
            r_md_lo  <= w_a_mag;
            r_md_b   <= w_b_mag;
            r_md_a   <= bus.Rdata1;
            r_md_div <= w_func[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (bus.Rdata2 == 32'h0);
            r_cnt    <= 6'(N - 1);
        end else if (r_state == StRun) begin
            r_md_hi  <= w_step_hi;
            r_md_lo  <= w_step_lo;
            r_cnt    <= r_cnt - 6'd1;
        end
    end

    // HI/LO: written by a finished mult/div or by MTHI/MTLO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hi <= HILO_INIT;
            r_lo <= HILO_INIT;
        end else if (r_state == StDone) begin
            r_hi <= w_fin_hi;
            r_lo <= w_fin_lo;
        end else if (w_accept) begin
            if (w_mthi) r_hi <= bus.Rdata1;
            if (w_mtlo) r_lo <= bus.Rdata1;
        end
    end

    assign bus.Busy      = w_busy;
    assign bus.OutValid  = r_out_valid;
    assign bus.Result    = r_result;
    assign bus.StoreData = r_store_data;
    assign bus.BrTaken   = r_br_taken;
    assign bus.BrTarget  = r_br_target;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops plus mult/div sequences.
module tb_ex_stage;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_stage_if bus ();

    ex_stage #(.BITS_PER_CYCLE(1), .HILO_INIT(32'h0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [31:0] ins, r1, r2, ed, npc;
        logic [31:0] res;
        logic        taken;
        logic        chk_bt;
        logic [31:0] bt;
    } vec_t;

    function automatic logic [31:0] mk_r(input logic [5:0] func, input logic [4:0] sh);
        return {6'h00, 15'h0, sh, func};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'h0, imm};
    endfunction

    function automatic vec_t mkv(input string nm, input logic [31:0] ins, r1, r2, ed, npc,
                                 res, input logic taken, chk_bt, input logic [31:0] bt);
        vec_t v;
        v.name = nm; v.ins = ins; v.r1 = r1; v.r2 = r2; v.ed = ed; v.npc = npc;
        v.res = res; v.taken = taken; v.chk_bt = chk_bt; v.bt = bt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, r1, r2, ed, npc);
        bus.InValid = 1'b1;
        bus.Ins     = ins;
        bus.Rdata1  = r1;
        bus.Rdata2  = r2;
        bus.Ed32    = ed;
        bus.NPC     = npc;
    endtask

    // Called #1 after an edge with Busy low; returns #1 after the following edge.
    task automatic apply(input vec_t v);
        drive(v.ins, v.r1, v.r2, v.ed, v.npc);
        @(posedge CLK); #1;
        bus.InValid = 1'b0;
        chk({v.name, " OutValid"}, {31'h0, bus.OutValid}, 32'd1);
        chk({v.name, " Result"}, bus.Result, v.res);
        chk({v.name, " BrTaken"}, {31'h0, bus.BrTaken}, {31'h0, v.taken});
        chk({v.name, " StoreData"}, bus.StoreData, v.r2);
        if (v.chk_bt) chk({v.name, " BrTarget"}, bus.BrTarget, v.bt);
    endtask

    // Issue a mult/div, hold a competing ADDI on the bus while Busy, count Busy cycles.
    task automatic run_md(input string nm, input logic [31:0] ins, a, b);
        int cnt = 0;
        int ov  = 0;
        drive(ins, a, b, 32'h0, 32'h0);
        @(posedge CLK); #1;
        drive(mk_i(6'h08, 16'h0001), 32'h1, 32'h1, 32'h1, 32'h0);
        while (bus.Busy && cnt < 100) begin
            if (bus.OutValid) ov++;
            cnt++;
            @(posedge CLK); #1;
        end
        bus.InValid = 1'b0;
        chk({nm, " Busy cycles"}, cnt, 33);
        chk({nm, " OutValid while Busy"}, ov, 0);
    endtask

    task automatic read_hilo(input string nm, input logic [31:0] hi, lo);
        apply(mkv({nm, " MFHI"}, mk_r(6'h10, 5'd0), 0, 0, 0, 0, hi, 1'b0, 1'b0, 0));
        apply(mkv({nm, " MFLO"}, mk_r(6'h12, 5'd0), 0, 0, 0, 0, lo, 1'b0, 1'b0, 0));
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = mkv("ADDI", mk_i(6'h08, 16'hFFFD), 5, 0, 32'hFFFFFFFD, 0, 2, 0, 0, 0);
        vecs[1]  = mkv("ORI", mk_i(6'h0D, 16'h8000), 1, 0, 32'hFFFF8000, 0, 32'h8001, 0, 0, 0);
        vecs[2]  = mkv("SLT", mk_r(6'h2A, 0), 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mkv("SLTU", mk_r(6'h2B, 0), 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mkv("BEQ", mk_i(6'h04, 16'hFFFF), 7, 7, 32'hFFFFFFFF, 32'h100, 0, 1, 1,
                       32'hFC);
        vecs[5]  = mkv("BNE", mk_i(6'h05, 16'hFFFF), 7, 7, 32'hFFFFFFFF, 32'h100, 0, 0, 1,
                       32'hFC);
        vecs[6]  = mkv("LUI", mk_i(6'h0F, 16'h1234), 0, 0, 32'h1234, 0, 32'h12340000, 0, 0, 0);
        vecs[7]  = mkv("SW", mk_i(6'h2B, 16'hFFF8), 32'h100, 32'hDEADBEEF, 32'hFFFFFFF8, 0,
                       32'hF8, 0, 0, 0);
        vecs[8]  = mkv("SRA", mk_r(6'h03, 5'd4), 0, 32'h80000000, 0, 0, 32'hF8000000, 0, 0, 0);
        vecs[9]  = mkv("SRLV", mk_r(6'h06, 0), 32'h24, 32'h80000000, 0, 0, 32'h08000000,
                       0, 0, 0);
        vecs[10] = mkv("NOR", mk_r(6'h27, 0), 32'h0F0F0F0F, 32'h00FF00FF, 0, 0, 32'hF000F000,
                       0, 0, 0);
        vecs[11] = mkv("SUB", mk_r(6'h22, 0), 0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
        vecs[12] = mkv("JAL", {6'h03, 26'h0000010}, 0, 0, 0, 32'h200, 32'h204, 0, 0, 0);
        vecs[13] = mkv("UNKNOWN", {6'h3F, 26'h0}, 3, 4, 5, 0, 0, 0, 0, 0);
        vecs[14] = mkv("ANDI", mk_i(6'h0C, 16'h00F0), 32'hFFFFFFFF, 0, 32'hFFFF00F0, 0, 32'hF0,
                       0, 0, 0);
        vecs[15] = mkv("JALR", mk_r(6'h09, 0), 32'h80, 0, 0, 32'h40, 32'h44, 0, 0, 0);

        // Reset dominates a valid instruction on the bus.
        drive(mk_r(6'h20, 0), 32'h11, 32'h22, 32'h33, 32'h44);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset Busy", {31'h0, bus.Busy}, 0);
        chk("reset OutValid", {31'h0, bus.OutValid}, 0);
        chk("reset Result", bus.Result, 0);
        chk("reset StoreData", bus.StoreData, 0);
        chk("reset BrTaken", {31'h0, bus.BrTaken}, 0);
        chk("reset BrTarget", bus.BrTarget, 0);
        RST = 1'b0;
        bus.InValid = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // OutValid is a single-cycle pulse.
        @(posedge CLK); #1;
        chk("OutValid pulse", {31'h0, bus.OutValid}, 0);

        run_md("MULT", mk_r(6'h18, 0), 32'hFFFFFFFE, 32'h3);
        chk("post-MULT OutValid", {31'h0, bus.OutValid}, 0);
        read_hilo("MULT", 32'hFFFFFFFF, 32'hFFFFFFFA);

        run_md("MULTU", mk_r(6'h19, 0), 32'hFFFFFFFF, 32'hFFFFFFFF);
        read_hilo("MULTU", 32'hFFFFFFFE, 32'h00000001);

        run_md("DIV", mk_r(6'h1A, 0), 32'hFFFFFFF9, 32'h2);
        read_hilo("DIV", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_md("DIV ovf", mk_r(6'h1A, 0), 32'h80000000, 32'hFFFFFFFF);
        read_hilo("DIV ovf", 32'h0, 32'h80000000);

        run_md("DIVU0", mk_r(6'h1B, 0), 32'd10, 32'd0);
        read_hilo("DIVU0", 32'd10, 32'hFFFFFFFF);

        // Reset in the middle of a divide.
        drive(mk_r(6'h1A, 0), 32'd100, 32'd7, 0, 0);
        @(posedge CLK); #1;
        bus.InValid = 1'b0;
        chk("mid-DIV Busy", {31'h0, bus.Busy}, 1);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("abort Busy", {31'h0, bus.Busy}, 0);
        chk("abort OutValid", {31'h0, bus.OutValid}, 0);
        read_hilo("abort", 32'h0, 32'h0);
        apply(mkv("ADD after abort", mk_r(6'h20, 0), 3, 4, 0, 0, 7, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the MIPS core, directly downstream of instruction decode.
- Consumes the decoded instruction word, the two register read values, the extended immediate and PC+4.
- Produces a registered ALU/address result, branch resolution, and store data.
- Owns the HI/LO registers and an iterative multiply/divide unit; holds Busy high to stall upstream while that unit runs.

Parameters:
- BITS_PER_CYCLE, 1, mult/div bits retired per cycle (legal values 1, 2, 4); iteration count N = 32/BITS_PER_CYCLE.
- HILO_INIT, 32'h0, reset value of HI and LO.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- InValid  in  1  Ins/operands are valid this cycle
- Ins  in  32  instruction word
- Rdata1  in  32  rs value
- Rdata2  in  32  rt value
- Ed32  in  32  extended immediate from decode
- NPC  in  32  PC+4 of Ins
- Busy  out  1  mult/div in progress; upstream must hold Ins/operands
- OutValid  out  1  Result/flags valid (registered)
- Result  out  32  ALU result, or memory address for LW/SW
- StoreData  out  32  Rdata2 registered, for SW
- BrTaken  out  1  BEQ/BNE condition true
- BrTarget  out  32  NPC + (sext(Ins[15:0]) << 2)

Behaviour:
- Reset (RST=1 at posedge): Busy=0, OutValid=0, Result=0, StoreData=0, BrTaken=0, BrTarget=0, HI=LO=HILO_INIT, FSM=IDLE. Reset aborts any in-flight mult/div; HI/LO are not updated.
- Accept condition: InValid && !Busy. While Busy, inputs are ignored and OutValid=0.
- Opcode/func encodings come from the shared common parameter header (standard MIPS values).
- Single-cycle ops, latency 1: accepted at edge k, outputs valid after edge k+1. OutValid pulses for one cycle per accepted non-mult/div instruction.
- Immediates:
  - ADDI/ADDIU/SLTI use Ed32 as given.
  - ANDI/ORI/XORI use {16'h0, Ed32[15:0]}.
  - LUI: Result = {Ins[15:0], 16'h0}.
  - LW/SW: Result = Rdata1 + sext(Ed32[15:0]).
- R-form funcs:
  - ADD/ADDU/SUB/SUBU wrap modulo 2^32; no overflow trap.
  - AND/OR/XOR/NOR.
  - SLT signed, SLTU unsigned.
  - SLL/SRL/SRA by Ins[10:6]; SLLV/SRLV/SRAV by Rdata1[4:0].
  - MFHI/MFLO return HI/LO.
  - JR/JALR: Result = NPC+4 for JALR link.
- JAL: Result = NPC+4. BEQ/BNE: BrTaken = (Rdata1 == Rdata2) / (!=); Result = 0. Non-branch ops: BrTaken = 0.
- Unknown op/func: Result = 0, OutValid still pulses.
- Mult/div FSM, states IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on accepted MULT/MULTU/DIV/DIVU, latch operands and go to RUN. Busy rises after the accepting edge.
  - RUN: N cycles. Shift-add multiply on magnitudes; restoring division on magnitudes.
  - DONE: apply signs, write HI/LO, Busy falls; next edge returns to IDLE. HI/LO are visible to an MFHI/MFLO accepted in the cycle after Busy falls.
  - Total Busy duration: N+1 cycles. No OutValid for mult/div.
- Multiply: {HI,LO} = full 64-bit product; signed for MULT, unsigned for MULTU.
- Divide: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- Divide by zero: LO = 32'hFFFFFFFF, HI = dividend; still takes N+1 cycles.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- MTHI/MTLO: write HI/LO directly at the accept edge, no Busy.

Test Plan:
- Reset, then ADDI with Rdata1=5, Ed32=32'hFFFFFFFD -> one cycle later OutValid=1, Result=2; all outputs 0 during RST.
- ORI with Ed32=32'hFFFF8000, Rdata1=1 -> Result=32'h00008001 (zero-extended). SLT -1 vs 1 -> 1; SLTU -> 0.
- BEQ with Rdata1=Rdata2=7, NPC=0x100, imm=0xFFFF -> BrTaken=1, BrTarget=0xFC. BNE with the same operands -> BrTaken=0.
- MULT 0xFFFFFFFE x 3 (BITS_PER_CYCLE=1) -> Busy high 33 cycles, InValid ignored meanwhile; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 10/0 -> LO=0xFFFFFFFF, HI=10.
- Assert RST in the middle of a DIV -> Busy=0 next cycle, HI/LO=HILO_INIT; a following ADD completes normally.
